// File: rtl/board_port_ctrl.sv
// Board memory port controller: arbitrates game-FSM cell accesses against a
// full-board clear sweep on the single port of board_mem.
module board_port_ctrl #(
    parameter int unsigned X_SIZE      = 12,
    parameter int unsigned Y_SIZE      = 12,
    parameter logic [1:0]  CLEAR_VALUE = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [7:0] a_addr,
    input  logic [1:0] a_wdata,
    output logic       a_gnt,
    output logic [1:0] a_rdata,
    output logic       a_rvalid,
    input  logic       clr_start,
    output logic       clr_busy,
    output logic       clr_done,
    output logic [7:0] mem_addr,
    output logic [1:0] mem_wdata,
    output logic       mem_w_nr,
    input  logic [1:0] mem_rdata
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [3:0] X_LAST = 4'(X_SIZE - 1);
    localparam logic [3:0] Y_LAST = 4'(Y_SIZE - 1);

    state_t     r_state;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic       r_prev_sweep;
    logic       r_sweep_end;
    logic       r_rd_pend;

    logic       w_a_issue;
    logic       w_sweep_issue;
    logic       w_last_cell;

    assign w_last_cell = (r_x == X_LAST) && (r_y == Y_LAST);

    // Once every cell is issued the FSM stays in CLEAR one more cycle so that
    // clr_done lines up with the cycle after the last write is on the port.
    always_comb begin
        w_a_issue     = 1'b0;
        w_sweep_issue = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    w_a_issue     = a_req;
                    w_sweep_issue = clr_start & ~a_req;
                end
                CLEAR: begin
                    if (a_req && (r_prev_sweep || r_sweep_end)) begin
                        w_a_issue = 1'b1;
                    end else if (!r_sweep_end) begin
                        w_sweep_issue = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_gnt   = w_a_issue;
    assign a_rdata = a_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_prev_sweep <= 1'b0;
            r_sweep_end  <= 1'b0;
            r_rd_pend    <= 1'b0;
            a_rvalid     <= 1'b0;
            clr_busy     <= 1'b0;
            clr_done     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_w_nr     <= 1'b0;
        end else begin
            if (w_a_issue) begin
                mem_addr  <= a_addr;
                mem_wdata <= a_wdata;
                mem_w_nr  <= a_we;
            end else if (w_sweep_issue) begin
                mem_addr  <= {r_y, r_x};
                mem_wdata <= CLEAR_VALUE;
                mem_w_nr  <= 1'b1;
            end else begin
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_w_nr  <= 1'b0;
            end

            r_rd_pend    <= w_a_issue & ~a_we;
            a_rvalid     <= r_rd_pend;
            r_prev_sweep <= w_sweep_issue;
            clr_done     <= 1'b0;

            if (w_sweep_issue) begin
                if (w_last_cell) begin
                    r_x         <= '0;
                    r_y         <= '0;
                    r_sweep_end <= 1'b1;
                end else if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 4'd1;
                end else begin
                    r_x <= r_x + 4'd1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (clr_start) begin
                        r_state  <= CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (r_sweep_end) begin
                        r_state     <= IDLE;
                        r_sweep_end <= 1'b0;
                        clr_busy    <= 1'b0;
                        clr_done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_port_ctrl.sv
// Directed bench for board_port_ctrl with a behavioural board_mem on port 1.
module tb_board_port_ctrl;

    localparam int unsigned XS = 12;
    localparam int unsigned YS = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req;
    logic       a_we;
    logic [7:0] a_addr;
    logic [1:0] a_wdata;
    logic       a_gnt;
    logic [1:0] a_rdata;
    logic       a_rvalid;
    logic       clr_start;
    logic       clr_busy;
    logic       clr_done;
    logic [7:0] mem_addr;
    logic [1:0] mem_wdata;
    logic       mem_w_nr;
    logic [1:0] mem_rdata;

    logic [1:0] mem [256];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    board_port_ctrl #(
        .X_SIZE     (XS),
        .Y_SIZE     (YS),
        .CLEAR_VALUE(2'b00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .clr_start(clr_start),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_w_nr (mem_w_nr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 2'b00;
        mem_rdata = 2'b00;
    end

    always @(posedge clk) begin
        if (mem_w_nr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned exp_addr(input int unsigned k);
        return ((k / XS) << 4) | (k % XS);
    endfunction

    task automatic do_write(input logic [7:0] addr, input logic [1:0] data);
        cyc(); a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data; #1;
        chk("wr_gnt", a_gnt, 1);
        cyc(); a_req = 1'b0; a_we = 1'b0; #1;
        chk("wr_port_w_nr", mem_w_nr, 1);
        chk("wr_port_addr", mem_addr, addr);
    endtask

    task automatic do_read(input logic [7:0] addr, input int unsigned exp);
        cyc(); a_req = 1'b1; a_we = 1'b0; a_addr = addr; #1;
        chk("rd_gnt", a_gnt, 1);
        cyc(); a_req = 1'b0; #1;
        chk("rd_rvalid_early", a_rvalid, 0);
        cyc(); #1;
        chk("rd_rvalid", a_rvalid, 1);
        chk("rd_rdata", a_rdata, exp);
    endtask

    // Uncontended sweep; a nonzero pulse_at re-pulses clr_start mid-sweep.
    task automatic run_sweep(input int unsigned pulse_at);
        cyc(); clr_start = 1'b1; a_req = 1'b0; #1;
        chk("sw_gnt0", a_gnt, 0);
        chk("sw_busy0", clr_busy, 0);
        for (int c = 1; c <= int'(XS * YS); c++) begin
            cyc(); clr_start = (c == int'(pulse_at)); #1;
            chk("sw_addr", mem_addr, exp_addr(c - 1));
            chk("sw_w_nr", mem_w_nr, 1);
            chk("sw_wdata", mem_wdata, 0);
            chk("sw_busy", clr_busy, 1);
            chk("sw_done_early", clr_done, 0);
        end
        cyc(); clr_start = 1'b0; #1;
        chk("sw_done", clr_done, 1);
        chk("sw_busy_end", clr_busy, 0);
        chk("sw_idle_w_nr", mem_w_nr, 0);
        chk("sw_idle_addr", mem_addr, 0);
        cyc(); #1;
        chk("sw_done_pulse", clr_done, 0);
    endtask

    initial begin
        int unsigned grants;
        int unsigned dones;

        rst = 1'b1; a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00;
        a_wdata = 2'b00; clr_start = 1'b0;
        #1;
        chk("rst_gnt_pre", a_gnt, 0);
        repeat (2) begin
            cyc(); #1;
            chk("rst_gnt", a_gnt, 0);
            chk("rst_rvalid", a_rvalid, 0);
            chk("rst_rdata", a_rdata, 0);
            chk("rst_busy", clr_busy, 0);
            chk("rst_done", clr_done, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
            chk("rst_w_nr", mem_w_nr, 0);
        end

        // Write 0x35 then read it back on the next cycle.
        cyc(); rst = 1'b0; a_req = 1'b1; a_we = 1'b1; a_addr = 8'h35; a_wdata = 2'b10; #1;
        chk("wr0_gnt", a_gnt, 1);
        cyc(); a_we = 1'b0; #1;
        chk("wr0_w_nr", mem_w_nr, 1);
        chk("wr0_addr", mem_addr, 8'h35);
        chk("wr0_wdata", mem_wdata, 2'b10);
        chk("rd1_gnt", a_gnt, 1);
        cyc(); a_req = 1'b0; #1;
        chk("rd1_w_nr", mem_w_nr, 0);
        chk("rd1_addr", mem_addr, 8'h35);
        chk("rd1_rvalid_early", a_rvalid, 0);
        cyc(); #1;
        chk("rd1_rvalid", a_rvalid, 1);
        chk("rd1_rdata", a_rdata, 2'b10);
        chk("idle_addr", mem_addr, 0);
        chk("idle_w_nr", mem_w_nr, 0);
        cyc(); #1;
        chk("rd1_rvalid_pulse", a_rvalid, 0);

        do_write(8'hBB, 2'b01);
        do_read(8'hBB, 1);

        run_sweep(0);
        do_read(8'h35, 0);
        do_read(8'hBB, 0);

        // Contended clear: reads of 0x35 alternate with sweep writes; the
        // sweep overwrites 0x35 (index 41) on port cycle 84.
        do_write(8'h35, 2'b11);
        cyc(); clr_start = 1'b1; a_req = 1'b1; a_we = 1'b0; a_addr = 8'h35; #1;
        chk("ct_gnt0", a_gnt, 1);
        grants = 0;
        for (int c = 1; c <= 2 * int'(XS * YS); c++) begin
            cyc(); clr_start = 1'b0; #1;
            chk("ct_gnt", a_gnt, (c % 2 == 0) ? 1 : 0);
            if (a_gnt && clr_busy) grants++;
            chk("ct_busy", clr_busy, 1);
            chk("ct_done_early", clr_done, 0);
            if (c % 2 == 0) begin
                chk("ct_sw_w_nr", mem_w_nr, 1);
                chk("ct_sw_addr", mem_addr, exp_addr((c - 2) / 2));
                chk("ct_rvalid", a_rvalid, 1);
                chk("ct_rdata", a_rdata, (c <= 84) ? 3 : 0);
            end else begin
                chk("ct_a_w_nr", mem_w_nr, 0);
                chk("ct_a_addr", mem_addr, 8'h35);
                chk("ct_rvalid_odd", a_rvalid, 0);
            end
        end
        cyc(); a_req = 1'b0; #1;
        chk("ct_done", clr_done, 1);
        chk("ct_busy_end", clr_busy, 0);
        chk("ct_grants", grants, XS * YS);
        chk("ct_rvalid_289", a_rvalid, 0);
        cyc(); #1;
        chk("ct_last_rvalid", a_rvalid, 1);
        chk("ct_last_rdata", a_rdata, 0);
        chk("ct_done_pulse", clr_done, 0);

        // Reset at cycle 50 of a sweep, with a read granted at cycle 49.
        cyc(); clr_start = 1'b1; #1;
        for (int c = 1; c <= 48; c++) begin
            cyc(); clr_start = 1'b0; #1;
        end
        cyc(); a_req = 1'b1; a_we = 1'b0; a_addr = 8'h20; #1;
        chk("rs_gnt49", a_gnt, 1);
        cyc(); rst = 1'b1; #1;
        chk("rs_gnt_in_rst", a_gnt, 0);
        chk("rs_port_read", mem_w_nr, 0);
        cyc(); rst = 1'b0; a_req = 1'b0; #1;
        chk("rs_busy", clr_busy, 0);
        chk("rs_rvalid", a_rvalid, 0);
        chk("rs_rdata", a_rdata, 0);
        chk("rs_addr", mem_addr, 0);
        chk("rs_w_nr", mem_w_nr, 0);
        dones = clr_done ? 1 : 0;
        for (int c = 0; c < 10; c++) begin
            cyc(); #1;
            if (clr_done) dones++;
        end
        chk("rs_no_done", dones, 0);

        // Restart from 0x00 with an ignored clr_start at sweep cycle 70.
        run_sweep(70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/board_port_ctrl.md
BOARD_PORT_CTRL -- requirements
Module: board_port_ctrl

Interface
REQ-001 SHALL have parameter X_SIZE, default 12: board columns; cell address is {y[3:0],x[3:0]}.
REQ-002 SHALL have parameter Y_SIZE, default 12: board rows.
REQ-003 SHALL have parameter CLEAR_VALUE, default 2'b00: data written to every cell by a clear sweep.
REQ-004 SHALL have port clk  input  1  control clock; the single clock of the block.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port a_req  input  1  game-FSM access request.
REQ-007 SHALL have port a_we  input  1  1 = write, 0 = read; sampled with a_req.
REQ-008 SHALL have port a_addr  input  8  cell address {y,x}.
REQ-009 SHALL have port a_wdata  input  2  write data.
REQ-010 SHALL have port a_gnt  output  1  request accepted this cycle; combinational from a_req and internal state.
REQ-011 SHALL have port a_rdata  output  2  read data, valid while a_rvalid is high.
REQ-012 SHALL have port a_rvalid  output  1  one-cycle read-data strobe.
REQ-013 SHALL have port clr_start  input  1  pulse that starts a clear sweep.
REQ-014 SHALL have port clr_busy  output  1  sweep in progress.
REQ-015 SHALL have port clr_done  output  1  one-cycle pulse when the sweep completes.
REQ-016 SHALL have port mem_addr  output  8  board_mem port-1 address, registered.
REQ-017 SHALL have port mem_wdata  output  2  board_mem port-1 write data, registered.
REQ-018 SHALL have port mem_w_nr  output  1  board_mem port-1 write/not-read, registered.
REQ-019 SHALL have port mem_rdata  input  2  board_mem port-1 read data, 1-cycle synchronous latency.

Function
REQ-020 SHALL use two states: IDLE and CLEAR; each state issues at most one memory access per cycle.
REQ-021 IDLE: a_gnt = a_req; clr_start high moves the FSM to CLEAR, starts the sweep at x=0,y=0 and sets clr_busy the next cycle.
REQ-022 SHALL process clr_start and a simultaneous a_req in the same IDLE cycle as follows: grant a_req; enter CLEAR.
REQ-023 Accepted access (a_req & a_gnt in cycle N): mem_addr, mem_wdata and mem_w_nr (= a_we) present it in cycle N+1.
REQ-024 Accepted read: a_rvalid=1 with a_rdata=mem_rdata in cycle N+2; a_rvalid=0 for writes.
REQ-025 Cycles with no access: mem_w_nr=0, mem_addr=0, mem_wdata=0 (harmless read, no a_rvalid).
REQ-026 CLEAR sweep order: x fastest from 0 to X_SIZE-1, then y from 0 to Y_SIZE-1; each access writes CLEAR_VALUE; cells with x>=X_SIZE or y>=Y_SIZE are never addressed.
REQ-027 SHALL apply this CLEAR arbitration: if a_req and the previous port slot was a sweep write, grant A; otherwise issue the next sweep write with a_gnt=0 (strict alternation under contention, no starvation of either side).
REQ-028 CLEAR with a_req low: one sweep write per cycle, X_SIZE*Y_SIZE consecutive cycles.
REQ-029 The last sweep write (address {Y_SIZE-1,X_SIZE-1}) appears on the port in cycle M; clr_busy falls and clr_done pulses in cycle M+1; FSM returns to IDLE in M+1.
REQ-030 clr_start while in CLEAR SHALL be ignored (no restart, no counter change).
REQ-031 A read granted in the cycle before clr_done SHALL still produce a_rvalid on schedule.

Reset
REQ-032 rst SHALL force IDLE, sweep counters=0, a_rvalid=0, a_rdata=0, clr_busy=0, clr_done=0, mem_addr=0, mem_wdata=0, mem_w_nr=0 on the next clk edge.
REQ-033 SHALL abort a sweep in progress on rst, with no clr_done pulse; any pending a_rvalid SHALL be discarded.
REQ-034 SHALL force a_gnt low while rst is high.

Verification
REQ-035 Reset: hold rst 2 cycles with a_req=1 -> all outputs 0, a_gnt 0 throughout.
REQ-036 Write/read: cycle 0 write 0x35 data 2'b10, cycle 1 read 0x35 -> mem_w_nr=1 in cycle 1; a_rvalid=1 with a_rdata=2'b10 in cycle 3.
REQ-037 Clear alone: clr_start at cycle 0 -> writes 0x00..0x0B,0x10..0xBB in cycles 1..144 with mem_w_nr=1 and data CLEAR_VALUE; clr_done pulse and clr_busy=0 in cycle 145; no address with low nibble >0xB appears.
REQ-038 Contended clear: clr_start plus a_req held high -> sweep and A grants alternate; 144 A grants; clr_done in cycle 289.
REQ-039 Reset mid-sweep: rst at cycle 50 of a clear -> clr_busy=0 next cycle, no clr_done, and the next clr_start restarts at address 0x00.
REQ-040 clr_start pulsed at cycle 70 of a sweep -> ignored; sweep address sequence and clr_done timing unchanged.
